// File: rtl/tx_fsm.sv
// Request-to-switch issue FSM: captures one request, decodes the switch index, waits for that
// switch to be free, then strobes it. Optional wait timeout is enabled by TX_FSM_TIMEOUT_EN.
module tx_fsm #(
    parameter int unsigned NUM_SW_INST = 5,
    parameter int unsigned W_WIDTH     = 8,
    parameter int unsigned A_WIDTH     = 8,
    parameter int unsigned SW_IDX_LSB  = 4,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [7:0]             req_op_id,
    input  logic [A_WIDTH-1:0]     req_addr,
    input  logic                   req_wr,
    input  logic [W_WIDTH-1:0]     req_wdata,
    input  logic [NUM_SW_INST-1:0] sw_busy,
    output logic [NUM_SW_INST-1:0] sel_en,
    output logic [7:0]             op_id,
    output logic [A_WIDTH-1:0]     addr_out,
    output logic                   wr_out,
    output logic [W_WIDTH-1:0]     wdata_out,
    output logic                   err_valid,
    output logic [7:0]             err_op_id,
    output logic [1:0]             err_code
);

    localparam int unsigned IDX_W = A_WIDTH - SW_IDX_LSB;
    localparam int unsigned CNT_W = 8;
    localparam logic [1:0]  ERR_DECODE  = 2'b01;
    localparam logic [1:0]  ERR_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {IDLE, DECODE, WAIT, ISSUE, ERR} state_t;

    state_t                 state_q, state_d;
    logic [7:0]             cap_op_q, cap_op_d;
    logic [A_WIDTH-1:0]     cap_addr_q, cap_addr_d;
    logic                   cap_wr_q, cap_wr_d;
    logic [W_WIDTH-1:0]     cap_wdata_q, cap_wdata_d;
    logic [NUM_SW_INST-1:0] sel_en_q, sel_en_d;
    logic [7:0]             op_id_q, op_id_d;
    logic [A_WIDTH-1:0]     addr_out_q, addr_out_d;
    logic                   wr_out_q, wr_out_d;
    logic [W_WIDTH-1:0]     wdata_out_q, wdata_out_d;
    logic                   err_valid_q, err_valid_d;
    logic [7:0]             err_op_id_q, err_op_id_d;
    logic [1:0]             err_code_q, err_code_d;

    logic [IDX_W-1:0]       idx;
    logic                   idx_ok;
    logic                   busy_sel;
    logic [NUM_SW_INST-1:0] idx_onehot;

`ifdef TX_FSM_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^{1'b0, CNT_W'(TIMEOUT_CYC)};
`endif

    assign req_ready = (state_q == IDLE) && !rst;

    // Index decode; loops keep selects width-clean and ignore other busy bits
    always_comb begin
        idx        = cap_addr_q[A_WIDTH-1:SW_IDX_LSB];
        idx_ok     = 32'(idx) < NUM_SW_INST;
        busy_sel   = 1'b0;
        idx_onehot = '0;
        for (int i = 0; i < NUM_SW_INST; i++) begin
            if (32'(idx) == i) begin
                busy_sel      = sw_busy[i];
                idx_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cap_op_d    = cap_op_q;
        cap_addr_d  = cap_addr_q;
        cap_wr_d    = cap_wr_q;
        cap_wdata_d = cap_wdata_q;
        sel_en_d    = '0;
        op_id_d     = op_id_q;
        addr_out_d  = addr_out_q;
        wr_out_d    = wr_out_q;
        wdata_out_d = wdata_out_q;
        err_valid_d = 1'b0;
        err_op_id_d = err_op_id_q;
        err_code_d  = err_code_q;
`ifdef TX_FSM_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cap_op_d    = req_op_id;
                    cap_addr_d  = req_addr;
                    cap_wr_d    = req_wr;
                    cap_wdata_d = req_wdata;
                    state_d     = DECODE;
                end
            end
            DECODE: begin
                if (!idx_ok) begin
                    state_d     = ERR;
                    err_valid_d = 1'b1;
                    err_op_id_d = cap_op_q;
                    err_code_d  = ERR_DECODE;
                end else begin
                    state_d = WAIT;
`ifdef TX_FSM_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            WAIT: begin
                // Outputs are loaded on the transition so they line up with the ISSUE/ERR state
                if (!busy_sel) begin
                    state_d     = ISSUE;
                    sel_en_d    = idx_onehot;
                    op_id_d     = cap_op_q;
                    addr_out_d  = cap_addr_q;
                    wr_out_d    = cap_wr_q;
                    wdata_out_d = cap_wdata_q;
                end else begin
`ifdef TX_FSM_TIMEOUT_EN
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(TIMEOUT_CYC)) begin
                        state_d     = ERR;
                        err_valid_d = 1'b1;
                        err_op_id_d = cap_op_q;
                        err_code_d  = ERR_TIMEOUT;
                    end
`endif
                end
            end
            ISSUE:   state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cap_op_q    <= '0;
            cap_addr_q  <= '0;
            cap_wr_q    <= 1'b0;
            cap_wdata_q <= '0;
            sel_en_q    <= '0;
            op_id_q     <= '0;
            addr_out_q  <= '0;
            wr_out_q    <= 1'b0;
            wdata_out_q <= '0;
            err_valid_q <= 1'b0;
            err_op_id_q <= '0;
            err_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            cap_op_q    <= cap_op_d;
            cap_addr_q  <= cap_addr_d;
            cap_wr_q    <= cap_wr_d;
            cap_wdata_q <= cap_wdata_d;
            sel_en_q    <= sel_en_d;
            op_id_q     <= op_id_d;
            addr_out_q  <= addr_out_d;
            wr_out_q    <= wr_out_d;
            wdata_out_q <= wdata_out_d;
            err_valid_q <= err_valid_d;
            err_op_id_q <= err_op_id_d;
            err_code_q  <= err_code_d;
        end
    end

`ifdef TX_FSM_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`endif

    assign sel_en    = sel_en_q;
    assign op_id     = op_id_q;
    assign addr_out  = addr_out_q;
    assign wr_out    = wr_out_q;
    assign wdata_out = wdata_out_q;
    assign err_valid = err_valid_q;
    assign err_op_id = err_op_id_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_tx_fsm.sv
// Directed self-checking bench for tx_fsm; timeout expectations follow TX_FSM_TIMEOUT_EN.
module tb_tx_fsm;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_op_id;
    logic [7:0] req_addr;
    logic       req_wr;
    logic [7:0] req_wdata;
    logic [4:0] sw_busy;
    logic [4:0] sel_en;
    logic [7:0] op_id;
    logic [7:0] addr_out;
    logic       wr_out;
    logic [7:0] wdata_out;
    logic       err_valid;
    logic [7:0] err_op_id;
    logic [1:0] err_code;

    int vec_cnt = 0;
    int err_cnt = 0;

    tx_fsm #(
        .NUM_SW_INST(5),
        .W_WIDTH    (8),
        .A_WIDTH    (8),
        .SW_IDX_LSB (4),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op_id(req_op_id),
        .req_addr (req_addr),
        .req_wr   (req_wr),
        .req_wdata(req_wdata),
        .sw_busy  (sw_busy),
        .sel_en   (sel_en),
        .op_id    (op_id),
        .addr_out (addr_out),
        .wr_out   (wr_out),
        .wdata_out(wdata_out),
        .err_valid(err_valid),
        .err_op_id(err_op_id),
        .err_code (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock edge, then settle 1 time unit past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [7:0] op, input logic [7:0] addr, input logic wr,
                           input logic [7:0] wd);
        req_valid = 1'b1;
        req_op_id = op;
        req_addr  = addr;
        req_wr    = wr;
        req_wdata = wd;
    endtask

    initial begin
        int sel_seen;
        int err_seen;
        int rdy_high;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_op_id = '0;
        req_addr  = '0;
        req_wr    = 1'b0;
        req_wdata = '0;
        sw_busy   = '0;

        // Reset state
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        step();
        step();
        chk("rst_sel", 32'(sel_en), 32'd0);
        chk("rst_op", 32'(op_id), 32'd0);
        chk("rst_errv", 32'(err_valid), 32'd0);
        chk("rst_errc", 32'(err_code), 32'd0);
        chk("rst_ready_hold", 32'(req_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_ready", 32'(req_ready), 32'd1);

        // Basic issue: idx 2, 3 cycles after acceptance
        set_req(8'h21, 8'h25, 1'b1, 8'hA5);
        step();
        req_valid = 1'b0;
        chk("basic_dec_ready", 32'(req_ready), 32'd0);
        chk("basic_dec_sel", 32'(sel_en), 32'd0);
        step();
        chk("basic_wait_sel", 32'(sel_en), 32'd0);
        step();
        chk("basic_sel", 32'(sel_en), 32'b00100);
        chk("basic_op", 32'(op_id), 32'h21);
        chk("basic_addr", 32'(addr_out), 32'h25);
        chk("basic_wr", 32'(wr_out), 32'd1);
        chk("basic_wdata", 32'(wdata_out), 32'hA5);
        step();
        chk("basic_sel_off", 32'(sel_en), 32'd0);
        chk("basic_op_hold", 32'(op_id), 32'h21);
        chk("basic_ready_back", 32'(req_ready), 32'd1);

        // Busy stall on idx 1 for 6 cycles
        sw_busy = 5'b00010;
        set_req(8'h33, 8'h10, 1'b0, 8'h5C);
        step();
        req_valid = 1'b0;
        rdy_high = 0;
        sel_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (req_ready) rdy_high++;
            if (sel_en != 0) sel_seen++;
            step();
        end
        chk("stall_ready_low", 32'(rdy_high), 32'd0);
        chk("stall_no_sel", 32'(sel_seen), 32'd0);
        sw_busy = 5'b00000;
        step();
        chk("stall_sel", 32'(sel_en), 32'b00010);
        chk("stall_op", 32'(op_id), 32'h33);
        chk("stall_wr", 32'(wr_out), 32'd0);
        step();

        // Decode error: idx 5 is out of range
        set_req(8'h7E, 8'h55, 1'b1, 8'h11);
        step();
        req_valid = 1'b0;
        step();
        chk("dec_errv", 32'(err_valid), 32'd1);
        chk("dec_errop", 32'(err_op_id), 32'h7E);
        chk("dec_errc", 32'(err_code), 32'b01);
        chk("dec_sel", 32'(sel_en), 32'd0);
        step();
        chk("dec_errv_off", 32'(err_valid), 32'd0);
        chk("dec_errc_hold", 32'(err_code), 32'b01);
        chk("dec_ready", 32'(req_ready), 32'd1);
        chk("dec_op_unchanged", 32'(op_id), 32'h33);

        // Other instances busy do not block idx 2
        sw_busy = 5'b11011;
        set_req(8'h62, 8'h2A, 1'b0, 8'h3C);
        step();
        req_valid = 1'b0;
        step();
        step();
        chk("mask_sel", 32'(sel_en), 32'b00100);
        chk("mask_op", 32'(op_id), 32'h62);
        step();
        sw_busy = '0;

        // Timeout on idx 0 held busy
        sw_busy = 5'b00001;
        set_req(8'h44, 8'h00, 1'b1, 8'h99);
        step();
        req_valid = 1'b0;
        step();
`ifdef TX_FSM_TIMEOUT_EN
        err_seen = 0;
        sel_seen = 0;
        for (int i = 0; i < 16; i++) begin
            if (err_valid) err_seen++;
            if (sel_en != 0) sel_seen++;
            step();
        end
        chk("to_early_err", 32'(err_seen), 32'd0);
        chk("to_no_sel", 32'(sel_seen), 32'd0);
        chk("to_errv", 32'(err_valid), 32'd1);
        chk("to_errc", 32'(err_code), 32'b10);
        chk("to_errop", 32'(err_op_id), 32'h44);
        step();
        chk("to_ready", 32'(req_ready), 32'd1);
`else
        err_seen = 0;
        sel_seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (err_valid) err_seen++;
            if (sel_en != 0) sel_seen++;
            step();
        end
        chk("nto_no_err", 32'(err_seen), 32'd0);
        chk("nto_no_sel", 32'(sel_seen), 32'd0);
        chk("nto_ready_low", 32'(req_ready), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("nto_ready_back", 32'(req_ready), 32'd1);
`endif
        sw_busy = '0;

        // Reset while waiting on busy idx 3
        sw_busy = 5'b01000;
        set_req(8'h5A, 8'h3F, 1'b1, 8'hC3);
        step();
        req_valid = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        #1;
        chk("mid_sel", 32'(sel_en), 32'd0);
        chk("mid_op", 32'(op_id), 32'd0);
        chk("mid_addr", 32'(addr_out), 32'd0);
        chk("mid_wr", 32'(wr_out), 32'd0);
        chk("mid_wdata", 32'(wdata_out), 32'd0);
        chk("mid_errv", 32'(err_valid), 32'd0);
        chk("mid_errop", 32'(err_op_id), 32'd0);
        chk("mid_errc", 32'(err_code), 32'd0);
        chk("mid_ready", 32'(req_ready), 32'd0);
        step();
        rst = 1'b0;
        sw_busy = '0;
        #1;
        chk("mid_ready_rel", 32'(req_ready), 32'd1);
        err_seen = 0;
        sel_seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (err_valid) err_seen++;
            if (sel_en != 0) sel_seen++;
            step();
        end
        chk("mid_no_err", 32'(err_seen), 32'd0);
        chk("mid_no_sel", 32'(sel_seen), 32'd0);

        // Back-to-back idx 0 then idx 2; fields change while busy and must be ignored
        set_req(8'h0A, 8'h03, 1'b0, 8'h01);
        step();
        set_req(8'h0B, 8'h2F, 1'b1, 8'h02);
        step();
        step();
        chk("b2b_sel_a", 32'(sel_en), 32'b00001);
        chk("b2b_op_a", 32'(op_id), 32'h0A);
        chk("b2b_addr_a", 32'(addr_out), 32'h03);
        chk("b2b_ready_issue", 32'(req_ready), 32'd0);
        sel_seen = 0;
        step();
        if (sel_en != 0) sel_seen++;
        chk("b2b_ready_idle", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        if (sel_en != 0) sel_seen++;
        step();
        if (sel_en != 0) sel_seen++;
        chk("b2b_gap_sel", 32'(sel_seen), 32'd0);
        step();
        chk("b2b_sel_b", 32'(sel_en), 32'b00100);
        chk("b2b_op_b", 32'(op_id), 32'h0B);
        chk("b2b_wdata_b", 32'(wdata_out), 32'h02);
        step();
        chk("b2b_sel_off", 32'(sel_en), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/tx_fsm.md
TX_FSM -- requirements
Module: tx_fsm

Interface
REQ-001 Parameters SHALL be: NUM_SW_INST, 5, number of switch instances; W_WIDTH, 8, data width; A_WIDTH, 8, address width; SW_IDX_LSB, 4, lowest address bit of the switch index; TIMEOUT_CYC, 16, wait-timeout limit.
REQ-002 Ports SHALL be:
- clk  in  1  the single clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  upstream request valid.
- req_ready  out  1  request accepted when high with req_valid.
- req_op_id  in  8  operation tag.
- req_addr  in  A_WIDTH  target address.
- req_wr  in  1  1 = write, 0 = read.
- req_wdata  in  W_WIDTH  write data.
- sw_busy  in  NUM_SW_INST  per-instance busy flags from the receive side.
- sel_en  out  NUM_SW_INST  one-hot issue strobe.
- op_id  out  8  issued tag.
- addr_out  out  A_WIDTH  issued address.
- wr_out  out  1  issued direction.
- wdata_out  out  W_WIDTH  issued write data.
- err_valid  out  1  error pulse.
- err_op_id  out  8  tag of the failed request.
- err_code  out  2  error cause: 01 = decode, 10 = timeout.

Function
REQ-003 The FSM SHALL have exactly the states IDLE, DECODE, WAIT, ISSUE and ERR.
REQ-004 req_ready SHALL be high exactly when the state is IDLE and rst is low; there is one request in flight at most.
REQ-005 On a cycle with req_valid and req_ready both high, the block SHALL capture req_op_id, req_addr, req_wr and req_wdata, and go to DECODE.
REQ-006 In DECODE: idx = req_addr >> SW_IDX_LSB (captured address). If idx >= NUM_SW_INST, the FSM SHALL go to ERR with code 01; otherwise it SHALL go to WAIT.
REQ-007 In WAIT: if sw_busy[idx] = 0, the FSM SHALL go to ISSUE; otherwise it SHALL stay in WAIT.
REQ-008 In ISSUE, for exactly one cycle: sel_en SHALL equal 1 << idx, and op_id, addr_out, wr_out and wdata_out SHALL carry the captured values. The FSM SHALL then go to IDLE.
REQ-009 Outside ISSUE, sel_en SHALL be 0. The payload outputs SHALL hold their last issued values.
REQ-010 Minimum latency from acceptance to sel_en SHALL be 3 cycles (accept at N, DECODE N+1, WAIT N+2, ISSUE N+3).
REQ-011 Two consecutive issues SHALL be at least 4 cycles apart, so a registered sw_busy from the receive side is visible before the next WAIT sample.
REQ-012 In ERR, for one cycle: err_valid SHALL be 1, err_op_id SHALL be the captured tag and err_code SHALL be set. sel_en SHALL stay 0. The FSM SHALL then go to IDLE.
REQ-013 err_valid SHALL be 0 in every other state; err_op_id and err_code SHALL hold their last values.
REQ-014 sw_busy bits other than sw_busy[idx] SHALL have no effect on the FSM.
REQ-015 A change of req_valid or of the request fields while the state is not IDLE SHALL be ignored.

Reset
REQ-016 On rst assertion, at any time, the state SHALL become IDLE. sel_en, op_id, addr_out, wr_out, wdata_out, err_valid, err_op_id, err_code and the timeout counter SHALL become 0.
REQ-017 A request in flight at reset SHALL be dropped and SHALL produce neither an issue nor an error.
REQ-018 req_ready SHALL be 0 while rst is high, and SHALL be 1 in the first clock cycle after release.

Configuration
REQ-019 With macro TX_FSM_TIMEOUT_EN defined:
- An 8-bit counter SHALL clear on entry to WAIT and increment on each WAIT cycle.
- When the counter reaches TIMEOUT_CYC with sw_busy[idx] still 1, the FSM SHALL go to ERR with code 10.
REQ-020 Without TX_FSM_TIMEOUT_EN, the counter SHALL not exist, WAIT SHALL be unbounded, and err_code 10 SHALL never occur.

Verification
REQ-021 Bench SHALL cover a basic issue: rst pulse, then a request with op_id=0x21, addr=0x25, wr=1, wdata=0xA5 and sw_busy=0. Required: sel_en=5'b00100 for one cycle, 3 cycles after acceptance, with op_id=0x21 and wdata_out=0xA5.
REQ-022 Bench SHALL cover a busy stall: addr=0x10 with sw_busy[1]=1 for 6 cycles, then cleared. Required: sel_en=5'b00010 one cycle after the clear, and req_ready=0 throughout the stall.
REQ-023 Bench SHALL cover a decode error: addr=0x55 (idx 5, NUM_SW_INST=5), op_id=0x7E. Required: err_valid pulse with err_op_id=0x7E and err_code=01, sel_en stays 0, and req_ready=1 on the next cycle.
REQ-024 Bench SHALL cover the timeout (macro defined, TIMEOUT_CYC=16): addr=0x00 with sw_busy[0] held at 1. Required: err_code=10 after 16 WAIT cycles and no sel_en. With the macro undefined, the bench SHALL see no err_valid within 100 cycles.
REQ-025 Bench SHALL cover reset mid-operation: assert rst while in WAIT. Required: all outputs 0 immediately, and no sel_en or err_valid after release.
REQ-026 Bench SHALL cover back-to-back requests to idx 0 and idx 2 with sw_busy=0. Required: two one-hot strobes 4 cycles apart, each carrying its own tag.
